// File: rtl/ram_sp_mbist.sv
// Synchronous single-port RAM with registered read and a March C- self-test engine.
// Optional first-failure logging (FAIL_ADDR/FAIL_DATA) under `RAM_SP_MBIST_FAIL_LOG_EN.
module ram_sp_mbist #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RD_EN,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  input  logic              BIST_START,
  output logic              BIST_BUSY,
  output logic              BIST_DONE,
`ifdef RAM_SP_MBIST_FAIL_LOG_EN
  output logic              BIST_FAIL,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [DATA_W-1:0] FAIL_DATA
`else
  output logic              BIST_FAIL
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nx;
  logic [ADDR_W-1:0] baddr, baddr_nx;
  logic              phase, phase_nx;
  logic              bwr, brd, start;
  logic [DATA_W-1:0] bwdata, bexp;
  logic [DATA_W-1:0] rbg;
  logic              descend;
  logic [ADDR_W-1:0] end_addr;

  logic              bist_busy, bist_done, bist_fail;
  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_data, cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;

  logic [ADDR_W-1:0] rd_addr, mem_wa;
  logic [DATA_W-1:0] rd_word, mem_wd;
  logic              mem_we;

  // M1..M4 each spend two cycles per address: read phase, then write phase.
  always_comb begin
    state_nx = state;
    baddr_nx = baddr;
    phase_nx = phase;
    bwr      = 1'b0;
    brd      = 1'b0;
    bwdata   = '0;
    bexp     = '0;
    start    = 1'b0;
    descend  = (state == S_M3) || (state == S_M4);
    rbg      = ((state == S_M2) || (state == S_M4)) ? '1 : '0;
    end_addr = descend ? '0 : LAST;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (BIST_START) begin
          start    = 1'b1;
          state_nx = S_M0;
          baddr_nx = '0;
          phase_nx = 1'b0;
        end
      end
      S_M0: begin
        bwr    = 1'b1;
        bwdata = '0;
        if (baddr == LAST) begin
          state_nx = S_M1;
          baddr_nx = '0;
        end else begin
          baddr_nx = baddr + 1'b1;
        end
      end
      S_M1, S_M2, S_M3, S_M4: begin
        if (!phase) begin
          brd      = 1'b1;
          bexp     = rbg;
          phase_nx = 1'b1;
        end else begin
          bwr      = 1'b1;
          bwdata   = ~rbg;
          phase_nx = 1'b0;
          if (baddr == end_addr) begin
            unique case (state)
              S_M1:    begin state_nx = S_M2; baddr_nx = '0;   end
              S_M2:    begin state_nx = S_M3; baddr_nx = LAST; end
              S_M3:    begin state_nx = S_M4; baddr_nx = LAST; end
              default: begin state_nx = S_M5; baddr_nx = '0;   end
            endcase
          end else begin
            baddr_nx = descend ? baddr - 1'b1 : baddr + 1'b1;
          end
        end
      end
      S_M5: begin
        brd  = 1'b1;
        bexp = '0;
        if (baddr == LAST) begin
          state_nx = S_FLUSH;
          baddr_nx = '0;
        end else begin
          baddr_nx = baddr + 1'b1;
        end
      end
      S_FLUSH: state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      baddr     <= '0;
      phase     <= 1'b0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_fail <= 1'b0;
      cmp_vld   <= 1'b0;
      cmp_data  <= '0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
    end else begin
      state   <= state_nx;
      baddr   <= baddr_nx;
      phase   <= phase_nx;
      cmp_vld <= brd;
      if (brd) begin
        cmp_data <= rd_word;
        cmp_exp  <= bexp;
        cmp_addr <= baddr;
      end
      if (cmp_vld && (cmp_data != cmp_exp)) bist_fail <= 1'b1;
      if (start) begin
        bist_busy <= 1'b1;
        bist_done <= 1'b0;
        bist_fail <= 1'b0;
      end else if (state == S_FLUSH) begin
        bist_busy <= 1'b0;
        bist_done <= 1'b1;
      end
    end
  end

`ifdef RAM_SP_MBIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;

  always_ff @(posedge CLK) begin
    if (RST || start) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (cmp_vld && (cmp_data != cmp_exp) && !bist_fail) begin
      fail_addr_q <= cmp_addr;
      fail_data_q <= cmp_data;
    end
  end

  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_DATA = fail_data_q;
`endif

  // The BIST engine owns the single port while busy; functional access is masked.
  always_comb begin
    rd_addr = bist_busy ? baddr : ADDR;
    rd_word = ({1'b0, rd_addr} < DEPTH_X) ? mem[rd_addr] : '0;
    mem_we  = 1'b0;
    mem_wa  = ADDR;
    mem_wd  = DIN;
    if (!RST) begin
      if (bist_busy) begin
        mem_we = bwr;
        mem_wa = baddr;
        mem_wd = bwdata;
      end else begin
        mem_we = WR_EN && ({1'b0, ADDR} < DEPTH_X);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DOUT <= '0;
    end else if (!bist_busy && RD_EN) begin
      DOUT <= rd_word;
    end
  end

  assign BIST_BUSY = bist_busy;
  assign BIST_DONE = bist_done;
  assign BIST_FAIL = bist_fail;

endmodule
